bram_tdp_clr: RTL and testbench
===============================

Name: bram_tdp_clr

Overview:
Parametrised true-dual-port block RAM on one clock, with per-byte write enables, selectable same-port read mode, an optional output pipeline register and a hardware clear engine. It is the general-purpose storage primitive for frame buffers and scratch memories. It infers to BRAM, because the array is never reset. Contents are zeroed or filled only on request, by the clear engine.

Parameters:
DATA_W, 16, word width; must be a multiple of BYTE_W.
ADDR_W, 16, address width; depth = 2**ADDR_W, and ADDR_W >= 1.
BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
RD_MODE, 0, same-port read behaviour on a write cycle: 0 write-first, 1 read-first, 2 no-change.
OUT_REG, 0, 1 adds an output register stage, so read latency becomes 2.
CLR_VAL, 0, DATA_W-bit fill value written by the clear engine.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset; does not affect array contents.
clr_start  in  1  one-cycle request to fill the whole array with CLR_VAL.
clr_busy  out  1  high while the clear engine owns both ports.
clr_done  out  1  one-cycle pulse after the final clear write.
a_en  in  1  port A enable.
a_we  in  NB  port A byte write enables; valid only when a_en=1.
a_addr  in  ADDR_W  port A address.
a_di  in  DATA_W  port A write data.
a_dout  out  DATA_W  port A read data.
a_vld  out  1  a_dout holds data for an enabled access.
b_en, b_we, b_addr, b_di, b_dout, b_vld: port B, identical to port A.

Behaviour:
- Reset values: a_dout=b_dout=0; a_vld=b_vld=0; clr_busy=0; clr_done=0; FSM=IDLE; clear counter=0; output pipe registers=0.
- Access: on a cycle with x_en=1, write every lane i whose x_we[i]=1, then read x_addr.
- Latency:
  - OUT_REG=0: x_dout and x_vld update at the next edge, so latency is 1.
  - OUT_REG=1: one further register stage, so latency is 2.
  - x_vld is x_en delayed by the same latency.
  - When x_en=0, x_dout holds its previous value and x_vld=0.
- RD_MODE on a same-port write:
  - 0 (write-first): dout returns the merged word, with new lanes where we=1 and old lanes elsewhere.
  - 1 (read-first): dout returns the old word.
  - 2 (no-change): when any we bit is set, dout holds its previous value and x_vld=0 for that access.
- Cross-port behaviour:
  - A read of an address written by the other port in the same cycle returns the old word, whatever RD_MODE is.
  - When both ports write the same address in the same cycle, port A wins on overlapping lanes; port B's non-overlapping lanes are still written.
- Clear FSM has three states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start=1. clr_busy rises at the same edge and the counter is set to 0.
  - In CLEAR, each cycle writes CLR_VAL to address {cnt,0} via port A and {cnt,1} via port B, then increments cnt (ADDR_W-1 bits). Total: 2**(ADDR_W-1) cycles.
  - CLEAR -> DONE after the write with cnt = all-ones.
  - DONE lasts one cycle: clr_done=1 and clr_busy=0. Then DONE -> IDLE.
  - clr_start is ignored while in CLEAR or DONE.
- While clr_busy=1:
  - User a_en and b_en are ignored; no user writes happen.
  - x_dout holds and x_vld=0. With OUT_REG=1, in-flight pipeline data still drains.
- Reset mid-clear: the FSM returns to IDLE immediately; clr_busy=0 and no clr_done pulse. The array is left partially cleared, with no defined boundary. The user must re-issue clr_start.
- clr_start asserted in the first cycle after rst_n deasserts is honoured.

Test Plan:
- Bench config: DATA_W=16, ADDR_W=4, BYTE_W=8, OUT_REG=0, RD_MODE=0.
- Write-first, partial lanes: A writes 0x1234 to addr 3 with we=11. A then writes 0xABCD to addr 3 with we=01. a_dout=0x12CD one cycle later and a_vld=1.
- Read-first and no-change: addr 5 holds 0x1111, then A writes 0x2222 with we=11.
  - RD_MODE=1: a_dout=0x1111.
  - RD_MODE=2: a_dout holds its previous value and a_vld=0. A following read of addr 5 returns 0x2222.
- Collisions:
  - A writes 0xAAAA (we=11) and B writes 0xBBBB (we=10) to addr 7 together; a later read of addr 7 gives 0xAAAA.
  - A writes 0xCCCC to addr 2 while B reads addr 2 (old value 0x0000); b_dout=0x0000.
- Clear with CLR_VAL=0x5A5A:
  - Pulse clr_start; clr_busy stays high for exactly 8 cycles, then clr_done pulses once.
  - User writes driven during the clear do not land.
  - Reading all 16 addresses returns 0x5A5A.
- Reset mid-clear: pull rst_n low on cycle 3 of CLEAR. clr_busy=0 asynchronously, every output is at its reset value and no clr_done pulse appears. A re-issued clear completes normally.
- OUT_REG=1: reads of addr 0..3 issued back-to-back produce data and x_vld 2 cycles later, at a throughput of one word per cycle.

Source files
------------

// File: rtl/bram_tdp_clr.sv
// True-dual-port block RAM with byte write enables, selectable same-port read
// mode, optional output register and a clear engine that fills the array
// through both ports at once (two words per cycle).
module bram_tdp_clr #(
    parameter int              DATA_W  = 16,
    parameter int              ADDR_W  = 16,
    parameter int              BYTE_W  = 8,
    parameter int              RD_MODE = 0,
    parameter int              OUT_REG = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_start,
    output logic                       clr_busy,
    output logic                       clr_done,
    input  logic                       a_en,
    input  logic [DATA_W/BYTE_W-1:0]   a_we,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_di,
    output logic [DATA_W-1:0]          a_dout,
    output logic                       a_vld,
    input  logic                       b_en,
    input  logic [DATA_W/BYTE_W-1:0]   b_we,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_di,
    output logic [DATA_W-1:0]          b_dout,
    output logic                       b_vld
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (ADDR_W > 1) ? ADDR_W - 1 : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clr_last;

    // Storage has no reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Per-port views, index 0 = port A, index 1 = port B.
    logic [1:0]             u_en;
    logic [1:0][NB-1:0]     u_we;
    logic [1:0][ADDR_W-1:0] u_addr;
    logic [1:0][DATA_W-1:0] u_di;

    logic [1:0][NB-1:0]     p_we;
    logic [1:0][ADDR_W-1:0] p_addr;
    logic [1:0][DATA_W-1:0] p_di;
    logic [CNT_W:0]         clr_pair;

    logic [1:0][DATA_W-1:0] old_w, merged_w, rd_data;
    logic [1:0]             rd_vld;

    logic [1:0][DATA_W-1:0] s1_dout_q, s1_dout_d, s2_dout_q, s2_dout_d;
    logic [1:0]             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;

    assign u_en   = {b_en, a_en};
    assign u_we   = {b_we, a_we};
    assign u_addr = {b_addr, a_addr};
    assign u_di   = {b_di, a_di};

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);
    assign clr_last = (ADDR_W == 1) ? 1'b1 : &cnt_q;

    // Clear engine next state: IDLE -> CLEAR -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clr_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Physical write port selection; on a same-address collision port B
    // loses only the lanes port A is also writing.
    always_comb begin
        p_we     = '0;
        p_addr   = '0;
        p_di     = '0;
        clr_pair = {cnt_q, 1'b0};
        for (int p = 0; p < 2; p++) begin
            if (clr_busy) begin
                p_we[p]   = '1;
                p_addr[p] = clr_pair[ADDR_W-1:0] | ADDR_W'(p);
                p_di[p]   = CLR_VAL;
            end else begin
                p_we[p]   = u_en[p] ? u_we[p] : '0;
                p_addr[p] = u_addr[p];
                p_di[p]   = u_di[p];
            end
        end
        if (p_addr[0] == p_addr[1]) p_we[1] = p_we[1] & ~p_we[0];
    end

    // Read side: array holds the pre-edge word, so cross-port reads see old data.
    always_comb begin
        old_w    = '0;
        merged_w = '0;
        rd_data  = '0;
        rd_vld   = '0;
        for (int p = 0; p < 2; p++) begin
            old_w[p]    = mem_q[u_addr[p]];
            merged_w[p] = old_w[p];
            for (int i = 0; i < NB; i++) begin
                if (u_we[p][i]) merged_w[p][i*BYTE_W +: BYTE_W] = u_di[p][i*BYTE_W +: BYTE_W];
            end
            rd_data[p] = (RD_MODE == 1) ? old_w[p] : merged_w[p];
            rd_vld[p]  = u_en[p] & ~clr_busy & ~((RD_MODE == 2) && (|u_we[p]));
        end
    end

    // Array write, per byte lane.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NB; i++) begin
                if (p_we[p][i]) mem_q[p_addr[p]][i*BYTE_W +: BYTE_W] <= p_di[p][i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Output stages hold their data when no valid access arrives.
    always_comb begin
        s1_vld_d = rd_vld;
        s2_vld_d = s1_vld_q;
        for (int p = 0; p < 2; p++) begin
            s1_dout_d[p] = rd_vld[p]   ? rd_data[p]   : s1_dout_q[p];
            s2_dout_d[p] = s1_vld_q[p] ? s1_dout_q[p] : s2_dout_q[p];
        end
    end

    // Output pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dout_q <= '0;
            s1_vld_q  <= '0;
            s2_dout_q <= '0;
            s2_vld_q  <= '0;
        end else begin
            s1_dout_q <= s1_dout_d;
            s1_vld_q  <= s1_vld_d;
            s2_dout_q <= s2_dout_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

    assign a_dout = (OUT_REG != 0) ? s2_dout_q[0] : s1_dout_q[0];
    assign b_dout = (OUT_REG != 0) ? s2_dout_q[1] : s1_dout_q[1];
    assign a_vld  = (OUT_REG != 0) ? s2_vld_q[0]  : s1_vld_q[0];
    assign b_vld  = (OUT_REG != 0) ? s2_vld_q[1]  : s1_vld_q[1];

endmodule

// File: tb/tb_bram_tdp_clr.sv
// Bench for bram_tdp_clr: four instances share one stimulus stream
// (write-first, read-first, no-change, write-first with output register)
// and are checked against a word-level model plus hand-written expectations.
module tb_bram_tdp_clr;
    localparam int NI = 4;
    localparam logic [15:0] CV = 16'h5A5A;
    localparam int RDM [NI] = '{0, 1, 2, 0};
    localparam int LAT [NI] = '{1, 1, 1, 2};

    logic clk = 1'b0, rst_n = 1'b1, clr_start = 1'b0;
    logic a_en, b_en;
    logic [1:0] a_we, b_we;
    logic [3:0] a_addr, b_addr;
    logic [15:0] a_di, b_di;
    logic [15:0] a_dout_w [NI], b_dout_w [NI];
    logic a_vld_w [NI], b_vld_w [NI], busy_w [NI], done_w [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bram_tdp_clr #(
            .DATA_W(16), .ADDR_W(4), .BYTE_W(8),
            .RD_MODE((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .OUT_REG((g == 3) ? 1 : 0),
            .CLR_VAL(CV)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .clr_start(clr_start),
            .clr_busy(busy_w[g]), .clr_done(done_w[g]),
            .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di),
            .a_dout(a_dout_w[g]), .a_vld(a_vld_w[g]),
            .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di),
            .b_dout(b_dout_w[g]), .b_vld(b_vld_w[g])
        );
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {bit vld; bit unk; logic [15:0] d;} res_t;
    logic [15:0] mm [16];
    bit          kn [16];
    int          clr_left;
    bit          m_done;
    res_t        pst [NI][2];
    logic [15:0] m_dout [NI][2];
    bit          m_vld [NI][2], m_unk [NI][2];

    function automatic void model_reset();
        clr_left = 0;
        m_done = 0;
        for (int a = 0; a < 16; a++) kn[a] = 0;
        for (int k = 0; k < NI; k++)
            for (int p = 0; p < 2; p++) begin
                pst[k][p] = '{vld: 1'b0, unk: 1'b0, d: 16'h0};
                m_dout[k][p] = 16'h0;
                m_vld[k][p] = 0;
                m_unk[k][p] = 0;
            end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d_busy", k), busy_w[k], clr_left > 0);
            chk($sformatf("i%0d_done", k), done_w[k], m_done);
            chk($sformatf("i%0d_a_vld", k), a_vld_w[k], m_vld[k][0]);
            chk($sformatf("i%0d_b_vld", k), b_vld_w[k], m_vld[k][1]);
            if (!m_unk[k][0]) chk($sformatf("i%0d_a_dout", k), a_dout_w[k], m_dout[k][0]);
            if (!m_unk[k][1]) chk($sformatf("i%0d_b_dout", k), b_dout_w[k], m_dout[k][1]);
        end
    endtask

    // One clock: predict the effect of the current inputs, then clock and compare.
    task automatic step();
        res_t r [NI][2];
        bit en [2];
        logic [1:0] we [2];
        logic [3:0] ad [2];
        logic [15:0] di [2];
        logic [15:0] old, mg;
        bit busy, done_nx;
        en = '{a_en, b_en}; we = '{a_we, b_we}; ad = '{a_addr, b_addr}; di = '{a_di, b_di};
        for (int k = 0; k < NI; k++)
            for (int p = 0; p < 2; p++) r[k][p] = '{vld: 1'b0, unk: 1'b0, d: 16'h0};
        if (rst_n) begin
            busy = clr_left > 0;
            done_nx = 0;
            if (!busy) begin
                for (int p = 0; p < 2; p++) if (en[p]) begin
                    old = mm[ad[p]];
                    mg = old;
                    for (int i = 0; i < 2; i++) if (we[p][i]) mg[i*8 +: 8] = di[p][i*8 +: 8];
                    for (int k = 0; k < NI; k++)
                        if (!(RDM[k] == 2 && we[p] != 0))
                            r[k][p] = '{vld: 1'b1,
                                        unk: !kn[ad[p]] && !(RDM[k] == 0 && we[p] == 2'b11),
                                        d: (RDM[k] == 0) ? mg : old};
                end
                // B first, then A, so A owns any lane both ports write.
                for (int p = 1; p >= 0; p--) if (en[p]) begin
                    for (int i = 0; i < 2; i++) if (we[p][i]) mm[ad[p]][i*8 +: 8] = di[p][i*8 +: 8];
                    if (we[p] == 2'b11) kn[ad[p]] = 1;
                end
            end
            if (busy) begin
                clr_left--;
                if (clr_left == 0) begin
                    done_nx = 1;
                    for (int a = 0; a < 16; a++) begin mm[a] = CV; kn[a] = 1; end
                end
            end else if (!m_done && clr_start) begin
                clr_left = 8;
            end
            m_done = done_nx;
            for (int k = 0; k < NI; k++)
                for (int p = 0; p < 2; p++) begin
                    res_t o;
                    if (LAT[k] == 1) o = r[k][p];
                    else begin o = pst[k][p]; pst[k][p] = r[k][p]; end
                    m_vld[k][p] = o.vld;
                    if (o.vld) begin m_dout[k][p] = o.d; m_unk[k][p] = o.unk; end
                end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_a(input logic en, input logic [1:0] we, input logic [3:0] ad, input logic [15:0] d);
        a_en = en; a_we = we; a_addr = ad; a_di = d;
    endtask
    task automatic set_b(input logic en, input logic [1:0] we, input logic [3:0] ad, input logic [15:0] d);
        b_en = en; b_we = we; b_addr = ad; b_di = d;
    endtask
    task automatic idle();
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    endtask

    // Run a clear already started; user writes are driven throughout.
    task automatic run_clear(input string tag);
        int n = 1, guard = 0;
        while (busy_w[0] && guard < 20) begin
            set_a(1, 2'b11, 4'(guard), 16'hDEAD);
            set_b(1, 2'b11, 4'(15 - guard), 16'hBEEF);
            step();
            if (busy_w[0]) n++;
            guard++;
        end
        idle();
        chk({tag, "_busy_len"}, n, 8);
        chk({tag, "_done_pulse"}, done_w[0], 1);
        step();
        chk({tag, "_done_once"}, done_w[0], 0);
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 4'(i), 0); set_b(1, 0, 4'(15 - i), 0);
            step();
            chk({tag, "_rd_a"}, a_dout_w[0], CV);
            chk({tag, "_rd_b"}, b_dout_w[0], CV);
        end
        idle();
    endtask

    typedef struct {
        logic a_en; logic [1:0] a_we; logic [3:0] a_addr; logic [15:0] a_di;
        logic b_en; logic [1:0] b_we; logic [3:0] b_addr; logic [15:0] b_di;
        logic ea_vld; logic [15:0] ea_d; bit ca;
        logic eb_vld; logic [15:0] eb_d; bit cb;
    } vec_t;
    vec_t tv [12];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1, 3, 3, 16'h1234, 0, 0, 0, 16'h0,    1, 16'h1234, 1, 0, 16'h0,    0};
        tv[1]  = '{1, 1, 3, 16'hABCD, 0, 0, 0, 16'h0,    1, 16'h12CD, 1, 0, 16'h0,    0};
        tv[2]  = '{1, 3, 5, 16'h1111, 0, 0, 0, 16'h0,    1, 16'h1111, 1, 0, 16'h0,    0};
        tv[3]  = '{1, 3, 5, 16'h2222, 0, 0, 0, 16'h0,    1, 16'h2222, 1, 0, 16'h0,    0};
        tv[4]  = '{1, 0, 5, 16'h0,    0, 0, 0, 16'h0,    1, 16'h2222, 1, 0, 16'h0,    0};
        tv[5]  = '{1, 3, 7, 16'hAAAA, 1, 2, 7, 16'hBBBB, 1, 16'hAAAA, 1, 1, 16'hBB5A, 1};
        tv[6]  = '{1, 0, 7, 16'h0,    1, 0, 7, 16'h0,    1, 16'hAAAA, 1, 1, 16'hAAAA, 1};
        tv[7]  = '{1, 3, 2, 16'h0000, 0, 0, 0, 16'h0,    1, 16'h0000, 1, 0, 16'h0,    0};
        tv[8]  = '{1, 3, 2, 16'hCCCC, 1, 0, 2, 16'h0,    1, 16'hCCCC, 1, 1, 16'h0000, 1};
        tv[9]  = '{0, 0, 0, 16'h0,    1, 0, 2, 16'h0,    0, 16'hCCCC, 1, 1, 16'hCCCC, 1};
        tv[10] = '{0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'hCCCC, 1, 0, 16'hCCCC, 1};
        tv[11] = '{1, 0, 3, 16'h0,    1, 0, 6, 16'h0,    1, 16'h12CD, 1, 1, 16'h5A5A, 1};

        idle();
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Clear with user writes driven while busy.
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("clr_busy_rise", busy_w[0], 1);
        run_clear("clr");

        // Directed vectors, write-first instance.
        foreach (tv[i]) begin
            set_a(tv[i].a_en, tv[i].a_we, tv[i].a_addr, tv[i].a_di);
            set_b(tv[i].b_en, tv[i].b_we, tv[i].b_addr, tv[i].b_di);
            step();
            chk($sformatf("tv%0d_a_vld", i), a_vld_w[0], tv[i].ea_vld);
            chk($sformatf("tv%0d_b_vld", i), b_vld_w[0], tv[i].eb_vld);
            if (tv[i].ca) chk($sformatf("tv%0d_a_dout", i), a_dout_w[0], tv[i].ea_d);
            if (tv[i].cb) chk($sformatf("tv%0d_b_dout", i), b_dout_w[0], tv[i].eb_d);
        end
        idle();

        // Read-first and no-change.
        set_a(1, 3, 5, 16'h1111); step();
        set_a(1, 0, 5, 16'h0);    step();
        chk("rd2_pre", a_dout_w[2], 16'h1111);
        set_a(1, 3, 5, 16'h2222); step();
        chk("rd1_old", a_dout_w[1], 16'h1111);
        chk("rd1_vld", a_vld_w[1], 1);
        chk("rd2_hold", a_dout_w[2], 16'h1111);
        chk("rd2_vld", a_vld_w[2], 0);
        set_a(1, 0, 5, 16'h0);    step();
        chk("rd2_after", a_dout_w[2], 16'h2222);
        chk("rd2_after_vld", a_vld_w[2], 1);

        // Output register: back-to-back reads, latency 2.
        for (int i = 0; i < 4; i++) begin set_a(1, 3, 4'(i), 16'h1000 + 16'(i)); step(); end
        idle(); step();
        for (int s = 0; s < 6; s++) begin
            if (s < 4) set_a(1, 0, 4'(s), 0); else idle();
            step();
            chk($sformatf("oreg_vld%0d", s), a_vld_w[3], (s >= 1 && s <= 4));
            if (s >= 1) chk($sformatf("oreg_d%0d", s), a_dout_w[3], 16'h1000 + 16'((s > 4) ? 3 : s - 1));
        end

        // Reset on cycle 3 of a clear, then clear requested right after release.
        clr_start = 1'b1; step(); clr_start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy_async", busy_w[0], 0);
        compare_all();
        @(posedge clk); #1;
        chk("rst_no_done", done_w[0], 0);
        step();
        rst_n = 1'b1;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("reclr_busy_rise", busy_w[0], 1);
        run_clear("reclr");

        // Randomized traffic with occasional clears.
        for (int c = 0; c < 400; c++) begin
            set_a($urandom_range(0, 1), 2'($urandom), 4'($urandom), 16'($urandom));
            set_b($urandom_range(0, 1), 2'($urandom), 4'($urandom), 16'($urandom));
            clr_start = ($urandom_range(0, 63) == 0);
            step();
        end
        clr_start = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
